// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: execution-unit result bus and register-file write ports shared by the writeback arbiter
interface wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int RN_W   = 6
);
    logic              alu1_req, alu2_req, advint_req, memunit_req, branch_req;
    logic [RN_W-1:0]   alu1_rd, alu2_rd, advint_rd, memunit_rd, branch_rd, advint_rd2;
    logic [DATA_W-1:0] alu1_data, alu2_data, advint_data, memunit_data, branch_data, advint_data2;
    logic              alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack;
    logic              wr1_en, wr2_en;
    logic [RN_W-1:0]   wr1_rn, wr2_rn, reg1_finished, reg2_finished;
    logic [DATA_W-1:0] wr1_data, wr2_data;

    modport master (
        output alu1_req, alu2_req, advint_req, memunit_req, branch_req,
        output alu1_rd, alu2_rd, advint_rd, memunit_rd, branch_rd, advint_rd2,
        output alu1_data, alu2_data, advint_data, memunit_data, branch_data, advint_data2,
        input  alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack,
        input  wr1_en, wr1_rn, wr1_data, wr2_en, wr2_rn, wr2_data,
        input  reg1_finished, reg2_finished
    );

    modport slave (
        input  alu1_req, alu2_req, advint_req, memunit_req, branch_req,
        input  alu1_rd, alu2_rd, advint_rd, memunit_rd, branch_rd, advint_rd2,
        input  alu1_data, alu2_data, advint_data, memunit_data, branch_data, advint_data2,
        output alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack,
        output wr1_en, wr1_rn, wr1_data, wr2_en, wr2_rn, wr2_data,
        output reg1_finished, reg2_finished
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin allocation of two register-file write ports among five execution units
module wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int RN_W   = 6
) (
    input logic       clk,
    input logic       rst,
    wb_arbiter_if.slave bus
);
    logic [4:0]        req;
    logic [RN_W-1:0]   rn_a [5];
    logic [DATA_W-1:0] dat_a [5];
    logic [1:0]        dem [5];
    logic [4:0]        grant;
    logic [3:0]        sum;
    logic [2:0]        idx, last;
    logic [1:0]        free;
    logic              any;
    logic [2:0]        ptr_d, ptr_q;
    logic              wr1_en_d, wr1_en_q, wr2_en_d, wr2_en_q;
    logic [RN_W-1:0]   wr1_rn_d, wr1_rn_q, wr2_rn_d, wr2_rn_q;
    logic [DATA_W-1:0] wr1_data_d, wr1_data_q, wr2_data_d, wr2_data_q;

    // Flatten the unit results; a lone advint rd2 stands in as its single write
    always_comb begin
        req      = {bus.branch_req, bus.memunit_req, bus.advint_req, bus.alu2_req, bus.alu1_req};
        rn_a[0]  = bus.alu1_rd;
        rn_a[1]  = bus.alu2_rd;
        rn_a[2]  = (bus.advint_rd != '0) ? bus.advint_rd : bus.advint_rd2;
        rn_a[3]  = bus.memunit_rd;
        rn_a[4]  = bus.branch_rd;
        dat_a[0] = bus.alu1_data;
        dat_a[1] = bus.alu2_data;
        dat_a[2] = (bus.advint_rd != '0) ? bus.advint_data : bus.advint_data2;
        dat_a[3] = bus.memunit_data;
        dat_a[4] = bus.branch_data;
        dem[0]   = {1'b0, bus.alu1_rd != '0};
        dem[1]   = {1'b0, bus.alu2_rd != '0};
        dem[2]   = {1'b0, bus.advint_rd != '0} + {1'b0, bus.advint_rd2 != '0};
        dem[3]   = {1'b0, bus.memunit_rd != '0};
        dem[4]   = {1'b0, bus.branch_rd != '0};
    end

    // Scan from ptr, granting whoever still fits; a blocked two-port advint does not stop the scan
    always_comb begin
        grant      = '0;
        free       = 2'd2;
        last       = ptr_q;
        any        = 1'b0;
        sum        = '0;
        idx        = '0;
        wr1_en_d   = 1'b0;
        wr1_rn_d   = wr1_rn_q;
        wr1_data_d = wr1_data_q;
        wr2_en_d   = 1'b0;
        wr2_rn_d   = wr2_rn_q;
        wr2_data_d = wr2_data_q;
        for (int k = 0; k < 5; k++) begin
            sum = {1'b0, ptr_q} + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (req[idx] && dem[idx] <= free) begin
                grant[idx] = 1'b1;
                if (dem[idx] == 2'd2) begin
                    wr1_en_d   = 1'b1;
                    wr1_rn_d   = rn_a[idx];
                    wr1_data_d = dat_a[idx];
                    wr2_en_d   = 1'b1;
                    wr2_rn_d   = bus.advint_rd2;
                    wr2_data_d = bus.advint_data2;
                end else if (dem[idx] == 2'd1 && free == 2'd2) begin
                    wr1_en_d   = 1'b1;
                    wr1_rn_d   = rn_a[idx];
                    wr1_data_d = dat_a[idx];
                end else if (dem[idx] == 2'd1) begin
                    wr2_en_d   = 1'b1;
                    wr2_rn_d   = rn_a[idx];
                    wr2_data_d = dat_a[idx];
                end
                free = free - dem[idx];
                if (dem[idx] != 2'd0) begin
                    last = idx;
                    any  = 1'b1;
                end
            end
        end
        ptr_d = any ? ((last == 3'd4) ? 3'd0 : last + 3'd1) : ptr_q;
    end

    // Register the write ports and the round-robin pointer; reset drops pending writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            wr1_en_q   <= 1'b0;
            wr1_rn_q   <= '0;
            wr1_data_q <= '0;
            wr2_en_q   <= 1'b0;
            wr2_rn_q   <= '0;
            wr2_data_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr1_en_q   <= wr1_en_d;
            wr1_rn_q   <= wr1_rn_d;
            wr1_data_q <= wr1_data_d;
            wr2_en_q   <= wr2_en_d;
            wr2_rn_q   <= wr2_rn_d;
            wr2_data_q <= wr2_data_d;
        end
    end

    assign bus.alu1_ack      = ~rst & grant[0];
    assign bus.alu2_ack      = ~rst & grant[1];
    assign bus.advint_ack    = ~rst & grant[2];
    assign bus.memunit_ack   = ~rst & grant[3];
    assign bus.branch_ack    = ~rst & grant[4];
    assign bus.wr1_en        = wr1_en_q;
    assign bus.wr1_rn        = wr1_rn_q;
    assign bus.wr1_data      = wr1_data_q;
    assign bus.wr2_en        = wr2_en_q;
    assign bus.wr2_rn        = wr2_rn_q;
    assign bus.wr2_data      = wr2_data_q;
    assign bus.reg1_finished = wr1_en_q ? wr1_rn_q : '0;
    assign bus.reg2_finished = wr2_en_q ? wr2_rn_q : '0;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, hand sequences and randomized run against a queue-based port model
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DATA_W(64), .RN_W(6)) bus ();
    wb_arbiter #(.DATA_W(64), .RN_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct packed {
        logic            rst;
        logic [4:0]      req;
        logic [4:0][5:0] rd;
        logic [5:0]      rd2;
        logic [4:0]      ack;
        logic            e1;
        logic [5:0]      r1;
        logic            e2;
        logic [5:0]      r2;
    } vec_t;

    typedef struct {
        logic [5:0]  rn;
        logic [63:0] d;
    } wr_t;

    int vectors = 0;
    int miscompares = 0;

    logic [4:0]  u_req;
    logic [5:0]  u_rd [5];
    logic [63:0] u_data [5];
    logic [5:0]  u_rd2;
    logic [63:0] u_data2;
    logic [4:0]  acked;

    int          m_ptr;
    logic        m_e1, m_e2;
    logic [5:0]  m_r1, m_r2;
    logic [63:0] m_d1, m_d2;

    vec_t tv [21];

    function automatic vec_t row(input logic r, input logic [4:0] q,
                                 input int a1, input int a2, input int ai, input int mu, input int br, input int ai2,
                                 input logic [4:0] ak, input logic e1, input int r1, input logic e2, input int r2);
        vec_t v;
        v.rst   = r;
        v.req   = q;
        v.rd[0] = 6'(a1);
        v.rd[1] = 6'(a2);
        v.rd[2] = 6'(ai);
        v.rd[3] = 6'(mu);
        v.rd[4] = 6'(br);
        v.rd2   = 6'(ai2);
        v.ack   = ak;
        v.e1    = e1;
        v.r1    = 6'(r1);
        v.e2    = e2;
        v.r2    = 6'(r2);
        return v;
    endfunction

    function automatic logic [63:0] data_of(input int u, input logic [5:0] rd);
        return {8'(u + 1), 50'd0, rd};
    endfunction

    function automatic logic [5:0] rnd_rn();
        return ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    endfunction

    function automatic logic [4:0] dut_ack();
        return {bus.branch_ack, bus.memunit_ack, bus.advint_ack, bus.alu2_ack, bus.alu1_ack};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive();
        bus.alu1_req     = u_req[0];
        bus.alu2_req     = u_req[1];
        bus.advint_req   = u_req[2];
        bus.memunit_req  = u_req[3];
        bus.branch_req   = u_req[4];
        bus.alu1_rd      = u_rd[0];
        bus.alu2_rd      = u_rd[1];
        bus.advint_rd    = u_rd[2];
        bus.memunit_rd   = u_rd[3];
        bus.branch_rd    = u_rd[4];
        bus.alu1_data    = u_data[0];
        bus.alu2_data    = u_data[1];
        bus.advint_data  = u_data[2];
        bus.memunit_data = u_data[3];
        bus.branch_data  = u_data[4];
        bus.advint_rd2   = u_rd2;
        bus.advint_data2 = u_data2;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_e1  = 1'b0;
        m_e2  = 1'b0;
        m_r1  = '0;
        m_r2  = '0;
        m_d1  = '0;
        m_d2  = '0;
    endtask

    // Each requester's writes are a list; it is granted when the list fits in the free ports.
    // Granted writes fill port 1 then port 2 in scan order.
    task automatic model_step(output logic [4:0] ea);
        wr_t wq[$];
        wr_t need[$];
        wr_t w;
        int  free;
        int  last;
        int  u;
        free = 2;
        last = -1;
        ea   = '0;
        for (int k = 0; k < 5; k++) begin
            u = (m_ptr + k) % 5;
            need.delete();
            if (!u_req[u]) continue;
            if (u_rd[u] != 0) begin
                w.rn = u_rd[u];
                w.d  = u_data[u];
                need.push_back(w);
            end
            if (u == 2 && u_rd2 != 0) begin
                w.rn = u_rd2;
                w.d  = u_data2;
                need.push_back(w);
            end
            if (need.size() <= free) begin
                ea[u] = 1'b1;
                free -= need.size();
                foreach (need[j]) wq.push_back(need[j]);
                if (need.size() > 0) last = u;
            end
        end
        m_e1 = wq.size() >= 1;
        m_e2 = wq.size() >= 2;
        if (m_e1) begin
            m_r1 = wq[0].rn;
            m_d1 = wq[0].d;
        end
        if (m_e2) begin
            m_r2 = wq[1].rn;
            m_d2 = wq[1].d;
        end
        if (last >= 0) m_ptr = (last + 1) % 5;
    endtask

    task automatic reset_all();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        u_req = '0;
        acked = '0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [4:0] ea;
        u_req   = '0;
        u_rd2   = '0;
        u_data2 = '0;
        acked   = '0;
        for (int u = 0; u < 5; u++) begin
            u_rd[u]   = '0;
            u_data[u] = '0;
        end
        drive();

        tv[0]  = row(1, 5'b11111, 1, 2, 3, 4, 5, 0, 5'b00000, 0, 0, 0, 0);
        tv[1]  = row(0, 5'b11111, 1, 2, 3, 4, 5, 0, 5'b00011, 0, 0, 0, 0);
        tv[2]  = row(0, 5'b11111, 1, 2, 3, 4, 5, 0, 5'b01100, 1, 1, 1, 2);
        tv[3]  = row(0, 5'b11111, 1, 2, 3, 4, 5, 0, 5'b10001, 1, 3, 1, 4);
        tv[4]  = row(0, 5'b11111, 1, 2, 3, 4, 5, 0, 5'b00110, 1, 5, 1, 1);
        tv[5]  = row(0, 5'b11111, 1, 2, 3, 4, 5, 0, 5'b11000, 1, 2, 1, 3);
        tv[6]  = row(0, 5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 4, 1, 5);
        tv[7]  = row(0, 5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 4, 0, 5);
        tv[8]  = row(0, 5'b00101, 11, 0, 13, 0, 0, 0, 5'b00101, 0, 4, 0, 5);
        tv[9]  = row(0, 5'b11100, 0, 0, 7, 9, 10, 8, 5'b11000, 1, 11, 1, 13);
        tv[10] = row(0, 5'b00100, 0, 0, 7, 0, 0, 8, 5'b00100, 1, 9, 1, 10);
        tv[11] = row(0, 5'b01011, 3, 4, 0, 0, 0, 0, 5'b01011, 1, 7, 1, 8);
        tv[12] = row(0, 5'b01101, 23, 0, 20, 22, 0, 21, 5'b00100, 1, 3, 1, 4);
        tv[13] = row(0, 5'b01001, 23, 0, 0, 22, 0, 0, 5'b01001, 1, 20, 1, 21);
        tv[14] = row(0, 5'b01110, 0, 30, 31, 33, 0, 32, 5'b01010, 1, 22, 1, 23);
        tv[15] = row(0, 5'b00100, 0, 0, 31, 0, 0, 32, 5'b00100, 1, 30, 1, 33);
        tv[16] = row(0, 5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 31, 1, 32);
        tv[17] = row(0, 5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 31, 0, 32);
        tv[18] = row(0, 5'b00001, 40, 0, 0, 0, 0, 0, 5'b00001, 0, 31, 0, 32);
        tv[19] = row(1, 5'b00001, 41, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
        tv[20] = row(0, 5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
            rst   = tv[i].rst;
            u_req = tv[i].req;
            for (int u = 0; u < 5; u++) begin
                u_rd[u]   = tv[i].rd[u];
                u_data[u] = data_of(u, tv[i].rd[u]);
            end
            u_rd2   = tv[i].rd2;
            u_data2 = {8'hEE, 50'd0, tv[i].rd2};
            drive();
            @(negedge clk);
            chk($sformatf("tv%0d ack", i), 64'(dut_ack()), 64'(tv[i].ack));
            chk($sformatf("tv%0d wr1_en", i), 64'(bus.wr1_en), 64'(tv[i].e1));
            chk($sformatf("tv%0d wr1_rn", i), 64'(bus.wr1_rn), 64'(tv[i].r1));
            chk($sformatf("tv%0d wr2_en", i), 64'(bus.wr2_en), 64'(tv[i].e2));
            chk($sformatf("tv%0d wr2_rn", i), 64'(bus.wr2_rn), 64'(tv[i].r2));
            chk($sformatf("tv%0d tag1", i), 64'(bus.reg1_finished), tv[i].e1 ? 64'(tv[i].r1) : 64'd0);
            chk($sformatf("tv%0d tag2", i), 64'(bus.reg2_finished), tv[i].e2 ? 64'(tv[i].r2) : 64'd0);
        end

        @(posedge clk);
        #1;
        u_req     = 5'b00001;
        u_rd[0]   = 6'd5;
        u_data[0] = 64'hDEAD;
        drive();
        @(negedge clk);
        chk("single ack", 64'(dut_ack()), 64'(5'b00001));
        @(posedge clk);
        #1;
        u_req = '0;
        drive();
        @(negedge clk);
        chk("single wr1_en", 64'(bus.wr1_en), 64'd1);
        chk("single wr1_rn", 64'(bus.wr1_rn), 64'd5);
        chk("single wr1_data", bus.wr1_data, 64'hDEAD);
        chk("single tag1", 64'(bus.reg1_finished), 64'd5);
        chk("single wr2_en", 64'(bus.wr2_en), 64'd0);
        chk("single tag2", 64'(bus.reg2_finished), 64'd0);

        reset_all();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 5; u++) begin
                if (!u_req[u] || acked[u]) begin
                    u_req[u]  = ($urandom_range(0, 3) != 0);
                    u_rd[u]   = rnd_rn();
                    u_data[u] = {$urandom, $urandom};
                    if (u == 2) begin
                        u_rd2   = ($urandom_range(0, 1) == 0) ? 6'd0 : rnd_rn();
                        u_data2 = {$urandom, $urandom};
                    end
                end
            end
            drive();
            @(negedge clk);
            chk("rnd wr1_en", 64'(bus.wr1_en), 64'(m_e1));
            chk("rnd wr1_rn", 64'(bus.wr1_rn), 64'(m_r1));
            chk("rnd wr1_data", bus.wr1_data, m_d1);
            chk("rnd wr2_en", 64'(bus.wr2_en), 64'(m_e2));
            chk("rnd wr2_rn", 64'(bus.wr2_rn), 64'(m_r2));
            chk("rnd wr2_data", bus.wr2_data, m_d2);
            chk("rnd tag1", 64'(bus.reg1_finished), m_e1 ? 64'(m_r1) : 64'd0);
            chk("rnd tag2", 64'(bus.reg2_finished), m_e2 ? 64'(m_r2) : 64'd0);
            model_step(ea);
            chk("rnd ack", 64'(dut_ack()), 64'(ea));
            acked = ea;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
